// File: rtl/vga_mem_arbiter_if.sv
// Bundle of every bus signal between the two requesters, the block RAM port and the
// memory arbiter.
//   Requester and memory side (modport master): drives cpu_req/cpu_we/cpu_addr/cpu_wdata,
//     vga_req/vga_addr and mem_dout. Receives grants, read returns, the memory drive and
//     vga_stall_cnt.
//   Arbiter side (modport slave): the reverse of master.
// Handshake: a requester raises req with its address (and, for the CPU, we/wdata). It holds
//   req high until the cycle in which req && gnt is seen. gnt is combinational in that same
//   cycle. The requester may change addr/we/wdata while it is waiting, and the grant uses
//   whatever values are present in the grant cycle. A granted read returns as a one-cycle
//   rvalid pulse READ_LAT cycles later, with rdata sampled in that same cycle.
interface vga_mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          vga_req;
  logic [AW-1:0] vga_addr;
  logic          vga_gnt;
  logic          vga_rvalid;
  logic [DW-1:0] vga_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_we;
  logic [DW-1:0] mem_dout;
  logic [7:0]    vga_stall_cnt;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, mem_dout,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, vga_gnt, vga_rvalid, vga_rdata,
    input  mem_addr, mem_din, mem_we, vga_stall_cnt
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, mem_dout,
    output cpu_gnt, cpu_rvalid, cpu_rdata, vga_gnt, vga_rvalid, vga_rdata,
    output mem_addr, mem_din, mem_we, vga_stall_cnt
  );
endinterface

// File: rtl/vga_mem_arbiter.sv
// vga_mem_arbiter: shares one single-port display/glyph RAM between the CPU load/store
// port and the VGA fetch logic. It grants one access per cycle, and VGA wins by default.
// A CPU that has been denied CPU_MAX_WAIT consecutive cycles is forced through. Read data
// returns to the owner READ_LAT cycles later, steered by a tag pipeline.
// Ports:
//   clk   - system clock, all state on posedge
//   reset - asynchronous, active-high
//   bus   - vga_mem_arbiter_if.slave (CPU port, VGA port, memory port, vga_stall_cnt)
module vga_mem_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 16,
  parameter int READ_LAT     = 1,
  parameter int CPU_MAX_WAIT = 4
) (
  input logic            clk,
  input logic            reset,
  vga_mem_arbiter_if.slave bus
);

  localparam int WW = $clog2(CPU_MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(CPU_MAX_WAIT);

  logic [WW-1:0] wait_cnt;
  logic [7:0]    stall_cnt;
  logic          force_cpu;
  logic          cpu_gnt_c;
  logic          vga_gnt_c;
  logic [AW-1:0] mem_addr_c;
  logic [DW-1:0] rdata_c;

  // Tag per in-flight access: bit 1 = CPU read, bit 0 = VGA read.
  logic [1:0] tag_q [READ_LAT];

  assign force_cpu = bus.cpu_req && (wait_cnt == WAIT_MAX);

  // Priority: a starved CPU first, then VGA, then an uncontested CPU.
  // Both grants are held low while reset is asserted.
  always_comb begin
    cpu_gnt_c = 1'b0;
    vga_gnt_c = 1'b0;
    if (!reset) begin
      if (force_cpu)        cpu_gnt_c = 1'b1;
      else if (bus.vga_req) vga_gnt_c = 1'b1;
      else if (bus.cpu_req) cpu_gnt_c = 1'b1;
    end
  end

  // When nobody is granted, the RAM address rests on the VGA address.
  assign mem_addr_c  = cpu_gnt_c ? bus.cpu_addr : bus.vga_addr;
  assign rdata_c     = bus.mem_dout;

  assign bus.cpu_gnt  = cpu_gnt_c;
  assign bus.vga_gnt  = vga_gnt_c;
  assign bus.mem_addr = mem_addr_c;
  assign bus.mem_din  = bus.cpu_wdata;
  assign bus.mem_we   = cpu_gnt_c && bus.cpu_we;

  // Consecutive denied-CPU cycles. A grant, or the request dropping, clears the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (!bus.cpu_req || cpu_gnt_c) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_MAX) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Saturating count of denied VGA cycles. Only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (bus.vga_req && !vga_gnt_c && stall_cnt != 8'hFF) begin
      stall_cnt <= stall_cnt + 8'd1;
    end
  end

  assign bus.vga_stall_cnt = stall_cnt;

  // The tag pipeline runs in step with the RAM read latency. Reset discards in-flight
  // reads, so none of them ever returns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < READ_LAT; i++) tag_q[i] <= 2'b00;
    end else begin
      tag_q[0] <= {cpu_gnt_c && !bus.cpu_we, vga_gnt_c};
      for (int i = 1; i < READ_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign bus.cpu_rvalid = tag_q[READ_LAT-1][1];
  assign bus.vga_rvalid = tag_q[READ_LAT-1][0];
  assign bus.cpu_rdata  = rdata_c;
  assign bus.vga_rdata  = rdata_c;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Self-checking bench for vga_mem_arbiter.
// Instance u_dut uses CPU_MAX_WAIT=4 and READ_LAT=2. It runs directed steps followed by
// randomized traffic. Each cycle is checked against a reference built from the arbitration
// rules: integer wait and stall counters, a shadow memory, and a queue of expected read
// returns tagged with their due cycle.
// Instance u_dut1 uses CPU_MAX_WAIT=1. It is run with both requests held, to show the
// alternating grants and the saturation of vga_stall_cnt.
module tb_vga_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int READ_LAT = 2;
  localparam int MAXW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic reset1 = 1'b1;
  always #5 clk = ~clk;

  vga_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  vga_mem_arbiter_if #(.AW(AW), .DW(DW)) bus1 ();

  vga_mem_arbiter #(.AW(AW), .DW(DW), .READ_LAT(READ_LAT), .CPU_MAX_WAIT(MAXW)) u_dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  vga_mem_arbiter #(.AW(AW), .DW(DW), .READ_LAT(1), .CPU_MAX_WAIT(1)) u_dut1 (
    .clk(clk), .reset(reset1), .bus(bus1)
  );

  // Block RAM model for u_dut. A location that has never been written reads as a fixed
  // pattern of its address.
  logic [DW-1:0] tb_mem [int];
  logic [DW-1:0] rd_pipe [READ_LAT];

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return a ^ 16'hA5C3;
  endfunction

  always @(posedge clk) begin
    rd_pipe[0] <= tb_mem.exists(int'(bus.mem_addr)) ? tb_mem[int'(bus.mem_addr)]
                                                    : init_val(bus.mem_addr);
    for (int k = 1; k < READ_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    if (bus.mem_we) tb_mem[int'(bus.mem_addr)] = bus.mem_din;
  end
  assign bus.mem_dout  = rd_pipe[READ_LAT-1];
  assign bus1.mem_dout = '0;

  // Scoreboard state.
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int m_wait = 0;
  int m_stall = 0;
  logic [DW-1:0] model_mem [int];
  // Expected-return entry, packed as {due_cycle[31:0], is_cpu, data[15:0]}.
  logic [48:0] exp_q [$];
  logic last_cpu_gnt = 1'b0;
  int cpu_gnt_cnt = 0;
  int vga_gnt_cnt = 0;
  int vga_rv_cnt = 0;
  int cpu_rv_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    return model_mem.exists(int'(a)) ? model_mem[int'(a)] : init_val(a);
  endfunction

  task automatic set_cpu(input logic req, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
  endtask

  task automatic set_vga(input logic req, input logic [AW-1:0] a);
    bus.vga_req = req; bus.vga_addr = a;
  endtask

  // One clock cycle of u_dut. The checks run on the falling edge, then the reference model
  // advances, and the task returns 1 time unit after the next rising edge.
  task automatic step();
    logic ec, ev, fc, exp_cv, exp_vv;
    logic [DW-1:0] exp_d;
    logic [48:0] e;
    @(negedge clk);
    ec = 1'b0; ev = 1'b0; exp_cv = 1'b0; exp_vv = 1'b0; exp_d = '0;
    if (reset) begin
      exp_q.delete();
      m_wait = 0;
      m_stall = 0;
    end else begin
      fc = bus.cpu_req && (m_wait == MAXW);
      ec = fc || (bus.cpu_req && !bus.vga_req);
      ev = bus.vga_req && !fc;
    end
    chk("cpu_gnt", bus.cpu_gnt, ec);
    chk("vga_gnt", bus.vga_gnt, ev);
    chk("mem_we", bus.mem_we, ec && bus.cpu_we);
    chk("mem_addr", bus.mem_addr, ec ? bus.cpu_addr : bus.vga_addr);
    if (ec && bus.cpu_we) chk("mem_din", bus.mem_din, bus.cpu_wdata);
    if (exp_q.size() > 0 && int'(exp_q[0][48:17]) == cyc) begin
      e = exp_q.pop_front();
      exp_cv = e[16];
      exp_vv = !e[16];
      exp_d  = e[15:0];
    end
    chk("cpu_rvalid", bus.cpu_rvalid, exp_cv);
    chk("vga_rvalid", bus.vga_rvalid, exp_vv);
    if (exp_cv) chk("cpu_rdata", bus.cpu_rdata, exp_d);
    if (exp_vv) chk("vga_rdata", bus.vga_rdata, exp_d);
    chk("vga_stall_cnt", bus.vga_stall_cnt, m_stall);
    if (bus.cpu_gnt) cpu_gnt_cnt++;
    if (bus.vga_gnt) vga_gnt_cnt++;
    if (bus.cpu_rvalid) cpu_rv_cnt++;
    if (bus.vga_rvalid) vga_rv_cnt++;
    if (!reset) begin
      if (ec && bus.cpu_we) model_mem[int'(bus.cpu_addr)] = bus.cpu_wdata;
      if (ec && !bus.cpu_we) exp_q.push_back({32'(cyc + READ_LAT), 1'b1, model_rd(bus.cpu_addr)});
      if (ev) exp_q.push_back({32'(cyc + READ_LAT), 1'b0, model_rd(bus.vga_addr)});
      if (bus.vga_req && !ev) m_stall = (m_stall < 255) ? m_stall + 1 : 255;
      if (bus.cpu_req && !ec) m_wait = (m_wait < MAXW) ? m_wait + 1 : MAXW;
      else m_wait = 0;
    end
    last_cpu_gnt = ec;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    set_cpu(1'b0, 1'b0, '0, '0);
    set_vga(1'b0, '0);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    bus1.cpu_req = 1'b1; bus1.cpu_we = 1'b0; bus1.cpu_addr = 16'h0001; bus1.cpu_wdata = '0;
    bus1.vga_req = 1'b1; bus1.vga_addr = 16'h0002;

    // Reset state: while reset is held, the requests get no grant.
    set_cpu(1'b1, 1'b1, 16'h0033, 16'h1234);
    set_vga(1'b1, 16'h0044);
    for (int i = 0; i < 3; i++) step();
    reset = 1'b0;
    idle(2);

    // Test 1: CPU write followed by a CPU read of the same address.
    set_cpu(1'b1, 1'b1, 16'h0010, 16'hBEEF);
    step();
    set_cpu(1'b1, 1'b0, 16'h0010, 16'h0000);
    step();
    idle(READ_LAT + 1);
    chk("t1_cpu_rv_cnt", cpu_rv_cnt, 1);

    // Test 2: VGA streaming of 8 back-to-back reads.
    vga_gnt_cnt = 0; vga_rv_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      set_vga(1'b1, 16'hF05A + 16'(i));
      step();
    end
    idle(READ_LAT + 1);
    chk("t2_vga_gnt_cnt", vga_gnt_cnt, 8);
    chk("t2_vga_rv_cnt", vga_rv_cnt, 8);
    chk("t2_stall", bus.vga_stall_cnt, 0);

    // Test 3: contention with both requests held. The CPU gets through every 5th cycle.
    cpu_gnt_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      set_cpu(1'b1, 1'b0, 16'h0300 + 16'(i), '0);
      set_vga(1'b1, 16'h0400 + 16'(i));
      step();
      if (i == 4) chk("t3_stall_after5", bus.vga_stall_cnt, 1);
    end
    chk("t3_cpu_gnt_cnt", cpu_gnt_cnt, 3);
    idle(READ_LAT + 1);

    // Test 4: a VGA read, then a CPU read in the next cycle.
    set_vga(1'b1, 16'h0100);
    step();
    set_vga(1'b0, '0);
    set_cpu(1'b1, 1'b0, 16'h0200, '0);
    step();
    idle(READ_LAT + 1);

    // Test 5: reset asserted right after a CPU read is granted.
    cpu_rv_cnt = 0;
    set_cpu(1'b1, 1'b0, 16'h0010, '0);
    step();
    reset = 1'b1;
    set_vga(1'b1, 16'h0555);
    for (int i = 0; i < 3; i++) step();
    chk("t5_cpu_rv_cnt", cpu_rv_cnt, 0);
    reset = 1'b0;
    step();
    idle(READ_LAT + 1);

    // Randomized traffic. An ungranted request stays pending, but its address and data are
    // re-randomized every cycle.
    for (int n = 0; n < 400; n++) begin
      if (!bus.cpu_req || last_cpu_gnt) bus.cpu_req = 1'($urandom_range(0, 1));
      bus.cpu_we    = 1'($urandom_range(0, 1));
      bus.cpu_addr  = 16'($urandom_range(0, 31));
      bus.cpu_wdata = 16'($urandom);
      bus.vga_req   = ($urandom_range(0, 3) != 0);
      bus.vga_addr  = 16'($urandom_range(0, 31));
      step();
    end
    idle(READ_LAT + 1);

    // Test 6: CPU_MAX_WAIT=1 with both requests held. Grants alternate, and the stall
    // count saturates at 255.
    @(posedge clk);
    #1;
    reset1 = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      chk("t6_cpu_gnt", bus1.cpu_gnt, (i % 2) == 1);
      chk("t6_vga_gnt", bus1.vga_gnt, (i % 2) == 0);
      chk("t6_stall", bus1.vga_stall_cnt, (i / 2 < 255) ? i / 2 : 255);
      @(posedge clk);
      #1;
    end
    chk("t6_stall_final", bus1.vga_stall_cnt, 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
